// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one single-port synchronous data SRAM between the core
// data port (master 0) and the loader/DMA port (master 1). Contended cycles
// use weighted priority: master 0 gets CORE_WEIGHT consecutive contended
// grants, then master 1 is forced in. Read data returns one cycle after the
// grant to the master that issued the read.
//
// Optional feature macro: DM_ARB_LOCK_EN
//   When defined, m1_lock lets master 1 hold the SRAM across several grants.
//   When undefined, m1_lock is accepted but ignored and no lock flop exists.
//
// state | meaning
// ------+---------------------------------------------------
// PRI0  | master 0 preferred on contention (reset state)
// PRI1  | master 1 preferred on contention
module dm_arbiter #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int CORE_WEIGHT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cs,
  input  logic [WIDTH-1:0]      m0_we,
  input  logic [31:0]           m0_addr,
  input  logic [WIDTH-1:0]      m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [WIDTH-1:0]      m0_rdata,
  input  logic                  m1_cs,
  input  logic [WIDTH-1:0]      m1_we,
  input  logic [31:0]           m1_addr,
  input  logic [WIDTH-1:0]      m1_wdata,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [WIDTH-1:0]      m1_rdata,
  output logic                  sram_cs,
  output logic [WIDTH-1:0]      sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WIDTH-1:0]      sram_wdata,
  input  logic [WIDTH-1:0]      sram_rdata
);

  localparam int CNT_W = $clog2(CORE_WEIGHT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_WEIGHT - 1);

  localparam logic [0:0] PRI0 = 1'b0;
  localparam logic [0:0] PRI1 = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             locked_q;
  logic             tag_m0_q, tag_m1_q;
  logic             gnt0, gnt1;

  // Byte offsets and address bits above the SRAM depth are dropped on purpose.
  logic unused_bits;
  assign unused_bits = ^{m0_addr[31:ADDR_WIDTH+2], m0_addr[1:0],
                         m1_addr[31:ADDR_WIDTH+2], m1_addr[1:0], m1_lock};

  // Grant decision; forced low while reset is asserted so nothing reaches the SRAM.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (locked_q) begin
        gnt1 = m1_cs;
      end else if (m0_cs && m1_cs) begin
        if (state_q == PRI1) gnt1 = 1'b1;
        else                 gnt0 = 1'b1;
      end else begin
        gnt0 = m0_cs;
        gnt1 = m1_cs;
      end
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // Next priority state and contended-run counter.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    if (gnt1) begin
      state_d   = PRI0;
      run_cnt_d = '0;
    end else if (gnt0 && m1_cs) begin
      // A contended master-0 grant only happens from PRI0.
      if (run_cnt_q == CNT_LAST) begin
        state_d   = PRI1;
        run_cnt_d = '0;
      end else begin
        run_cnt_d = run_cnt_q + 1'b1;
      end
    end
  end

  // Priority state and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PRI0;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

`ifdef DM_ARB_LOCK_EN
  // Lock follows m1_lock on every master-1 grant, so the first unlocked grant releases it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      locked_q <= 1'b0;
    else if (gnt1) locked_q <= m1_lock;
  end
`else
  assign locked_q = 1'b0;
`endif

  // SRAM request mux from whichever master holds the grant.
  always_comb begin
    sram_cs    = gnt0 | gnt1;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (gnt0) begin
      sram_we    = m0_we;
      sram_addr  = m0_addr[ADDR_WIDTH+1:2];
      sram_wdata = m0_wdata;
    end else if (gnt1) begin
      sram_we    = m1_we;
      sram_addr  = m1_addr[ADDR_WIDTH+1:2];
      sram_wdata = m1_wdata;
    end
  end

  // Read-owner tag: one cycle behind the grant, matching the SRAM latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_m0_q <= 1'b0;
      tag_m1_q <= 1'b0;
    end else begin
      tag_m0_q <= gnt0 && (m0_we == '0);
      tag_m1_q <= gnt1 && (m1_we == '0);
    end
  end

  assign m0_rvalid = tag_m0_q;
  assign m1_rvalid = tag_m1_q;
  assign m0_rdata  = tag_m0_q ? sram_rdata : '0;
  assign m1_rdata  = tag_m1_q ? sram_rdata : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scenarios plus randomized traffic for dm_arbiter,
// checked against a behavioural reference model and a reference memory image.
module tb_dm_arbiter;

  localparam int W     = 32;
  localparam int AW    = 10;
  localparam int CW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_cs = 1'b0, m1_cs = 1'b0, m1_lock = 1'b0;
  logic [W-1:0]  m0_we = '0, m1_we = '0, m0_wdata = '0, m1_wdata = '0;
  logic [31:0]   m0_addr = '0, m1_addr = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_cs;
  logic [W-1:0]  m0_rdata, m1_rdata, sram_we, sram_wdata, sram_rdata;
  logic [AW-1:0] sram_addr;

  int n_cmp = 0;
  int n_err = 0;

  dm_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .CORE_WEIGHT(CW)) dut (
    .clk(clk), .rst(rst),
    .m0_cs(m0_cs), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_cs(m1_cs), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] init_word(input int i);
    return 32'hA5C3_0000 ^ (32'(i) * 32'h0001_0011);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // ---------------- reference model ----------------
  // owed: master 1 is due the next contended cycle; streak: contended
  // master-0 grants since master 1 was last served.
  int          streak;
  bit          owed;
  bit          locked_m;
  logic [1:0]  exp_gnt;
  logic        exp_rv0, exp_rv1;
  logic [W-1:0] exp_rd;
  logic [W-1:0] sram_mem [DEPTH];
  logic [W-1:0] ref_mem  [DEPTH];
  bit          mem_ready = 1'b0;

  assign exp_gnt = !rst ? 2'b00 :
                   locked_m ? {m1_cs, 1'b0} :
                   (m0_cs && m1_cs) ? (owed ? 2'b10 : 2'b01) :
                   {m1_cs, m0_cs};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak   <= 0;
      owed     <= 1'b0;
      locked_m <= 1'b0;
      exp_rv0  <= 1'b0;
      exp_rv1  <= 1'b0;
    end else begin
      exp_rv0 <= exp_gnt[0] && (m0_we == '0);
      exp_rv1 <= exp_gnt[1] && (m1_we == '0);
      if (exp_gnt[1]) begin
        owed   <= 1'b0;
        streak <= 0;
`ifdef DM_ARB_LOCK_EN
        locked_m <= m1_lock;
`endif
      end else if (exp_gnt[0] && m1_cs) begin
        if (streak + 1 == CW) begin
          owed   <= 1'b1;
          streak <= 0;
        end else begin
          streak <= streak + 1;
        end
      end
    end
  end

  // Behavioural SRAM attached to the DUT, and the model's own memory image.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) begin
        sram_mem[i] <= init_word(i);
        ref_mem[i]  <= init_word(i);
      end
      mem_ready <= 1'b1;
    end else begin
      if (sram_cs) begin
        if (sram_we != '0)
          sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_we) | (sram_wdata & sram_we);
        else
          sram_rdata <= sram_mem[sram_addr];
      end
      if (exp_gnt[0]) begin
        if (m0_we != '0)
          ref_mem[word_of(m0_addr)] <= (ref_mem[word_of(m0_addr)] & ~m0_we) | (m0_wdata & m0_we);
        else
          exp_rd <= ref_mem[word_of(m0_addr)];
      end else if (exp_gnt[1]) begin
        if (m1_we != '0)
          ref_mem[word_of(m1_addr)] <= (ref_mem[word_of(m1_addr)] & ~m1_we) | (m1_wdata & m1_we);
        else
          exp_rd <= ref_mem[word_of(m1_addr)];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    m0_cs = 1'b0; m0_we = '0; m0_addr = '0; m0_wdata = '0;
    m1_cs = 1'b0; m1_we = '0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    m0_cs = 1'b1; m0_we = '1; m0_addr = 32'h24; m0_wdata = 32'h1234_5678;
    m1_cs = 1'b1; m1_we = '1; m1_addr = 32'h38; m1_wdata = 32'h8765_4321;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({m0_gnt, m1_gnt, sram_cs, m0_rvalid, m1_rvalid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got gnt0/gnt1/cs/rv0/rv1=%b want 00000",
               {m0_gnt, m1_gnt, sram_cs, m0_rvalid, m1_rvalid});
    end
    n_cmp++;
    if ({sram_we, sram_addr, sram_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_sram: got we=%h addr=%h wdata=%h want all 0", sram_we, sram_addr, sram_wdata);
    end
    n_cmp++;
    if ({m0_rdata, m1_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    m0_cs = 1'b1; m0_addr = 32'h10;
    #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt, sram_addr} !== {2'b01, 10'd4}) begin
      n_err++;
      $display("FAIL reset_first_grant: got gnt=%b addr=%0d want gnt=01 addr=4", {m1_gnt, m0_gnt}, sram_addr);
    end
    @(negedge clk);
    m0_cs = 1'b0;
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== init_word(4)) begin
      n_err++;
      $display("FAIL reset_first_read: got rv=%b data=%h want rv=1 data=%h", m0_rvalid, m0_rdata, init_word(4));
    end
  endtask

  task automatic test_solo_write_read();
    @(negedge clk);
    idle_inputs();
    m1_cs = 1'b1; m1_we = '1; m1_addr = 32'h40; m1_wdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b10 || sram_we !== '1 || sram_addr !== 10'd16 || sram_wdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL solo_write: got gnt=%b we=%h addr=%0d wdata=%h want 10 ffffffff 16 deadbeef",
               {m1_gnt, m0_gnt}, sram_we, sram_addr, sram_wdata);
    end
    @(negedge clk);
    m1_we = '0; m1_wdata = '0;
    #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b10 || sram_we !== '0 || sram_addr !== 10'd16 ||
        {m1_rvalid, m0_rvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL solo_read_issue: got gnt=%b we=%h addr=%0d rv=%b want 10 0 16 00",
               {m1_gnt, m0_gnt}, sram_we, sram_addr, {m1_rvalid, m0_rvalid});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++;
    if ({m1_rvalid, m0_rvalid} !== 2'b10 || m1_rdata !== 32'hDEAD_BEEF || m0_rdata !== '0) begin
      n_err++;
      $display("FAIL solo_read_data: got rv=%b m1=%h m0=%h want 10 deadbeef 0",
               {m1_rvalid, m0_rvalid}, m1_rdata, m0_rdata);
    end
  endtask

  task automatic test_weighting();
    int pat [10];
    pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    apply_reset();
    @(negedge clk);
    m0_cs = 1'b1; m0_addr = 32'h100;
    m1_cs = 1'b1; m1_addr = 32'h204;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 10) idle_inputs();
      #1;
      if (c < 10) begin
        n_cmp++;
        if ({m1_gnt, m0_gnt} !== ((pat[c] == 1) ? 2'b10 : 2'b01)) begin
          n_err++;
          $display("FAIL weight_gnt[%0d]: got %b want owner %0d", c, {m1_gnt, m0_gnt}, pat[c]);
        end
      end
      if (c > 0) begin
        n_cmp++;
        if (pat[c-1] == 1 ? ({m1_rvalid, m0_rvalid} !== 2'b10 || m1_rdata !== init_word(129) || m0_rdata !== '0)
                          : ({m1_rvalid, m0_rvalid} !== 2'b01 || m0_rdata !== init_word(64) || m1_rdata !== '0)) begin
          n_err++;
          $display("FAIL weight_rv[%0d]: got rv=%b m0=%h m1=%h want owner %0d",
                   c, {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata, pat[c-1]);
        end
      end
    end
  endtask

  task automatic test_addr_wrap();
    @(negedge clk);
    idle_inputs();
    m0_cs = 1'b1; m0_addr = 32'h1000;
    #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b01 || sram_addr !== '0) begin
      n_err++;
      $display("FAIL wrap_addr: got gnt=%b addr=%0d want 01 0", {m1_gnt, m0_gnt}, sram_addr);
    end
    @(negedge clk);
    m0_addr = 32'h0;
    #1;
    n_cmp++;
    if (sram_addr !== '0 || m0_rvalid !== 1'b1 || m0_rdata !== init_word(0)) begin
      n_err++;
      $display("FAIL wrap_data: got addr=%0d rv=%b data=%h want 0 1 %h", sram_addr, m0_rvalid, m0_rdata, init_word(0));
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== init_word(0)) begin
      n_err++;
      $display("FAIL wrap_plain: got rv=%b data=%h want 1 %h", m0_rvalid, m0_rdata, init_word(0));
    end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    @(negedge clk);
    m0_cs = 1'b1; m0_addr = 32'h8;
    m1_cs = 1'b1; m1_addr = 32'h30;
    // Four contended master-0 reads leave the arbiter preferring master 1.
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      n_err++;
      $display("FAIL midrst_pre_gnt: got %b want 01", {m1_gnt, m0_gnt});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (m0_rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_rv_before: got %b want 1", m0_rvalid);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, m0_gnt, m1_gnt} !== 4'b0 || m0_rdata !== '0) begin
      n_err++;
      $display("FAIL midrst_async: got rv0/rv1/g0/g1=%b rdata=%h want 0000 0",
               {m0_rvalid, m1_rvalid, m0_gnt, m1_gnt}, m0_rdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      n_err++;
      $display("FAIL midrst_pri0: got %b want 01 after release", {m1_gnt, m0_gnt});
    end
    @(negedge clk);
    idle_inputs();
  endtask

`ifdef DM_ARB_LOCK_EN
  task automatic test_lock();
    logic cs1  [6];
    logic lk   [6];
    logic [1:0] want [6];
    cs1  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    lk   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    want = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b01};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) begin m0_cs = 1'b1; m0_addr = 32'h20; end
      m1_cs = cs1[c]; m1_lock = lk[c]; m1_addr = 32'h60; m1_we = '1; m1_wdata = 32'(c);
      #1;
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== want[c]) begin
        n_err++;
        $display("FAIL lock_gnt[%0d]: got %b want %b", c, {m1_gnt, m0_gnt}, want[c]);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    logic [1:0] eg;
    logic [1:0] prev = 2'b00;
    logic [W-1:0] w0, w1;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (!m0_cs || prev[0]) begin
        m0_cs = ($urandom_range(0, 99) < 60);
        m0_we = ($urandom_range(0, 1) == 1) ? '0 : (($urandom_range(0, 1) == 1) ? '1 : W'($urandom));
        m0_addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
        m0_wdata = W'($urandom);
      end
      if (!m1_cs || prev[1]) begin
        m1_cs = ($urandom_range(0, 99) < 60);
        m1_we = ($urandom_range(0, 1) == 1) ? '0 : (($urandom_range(0, 1) == 1) ? '1 : W'($urandom));
        m1_addr = ($urandom_range(0, 3) == 0) ? $urandom
                  : (($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2));
        m1_wdata = W'($urandom);
      end
      m1_lock = ($urandom_range(0, 3) == 0);
      #1;
      eg = exp_gnt;
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== eg) begin
        n_err++;
        $display("FAIL rand_gnt[%0d]: got %b want %b", c, {m1_gnt, m0_gnt}, eg);
      end
      n_cmp++;
      if (eg == 2'b00 ? ({sram_cs, sram_we, sram_addr, sram_wdata} !== '0) :
          eg[0] ? (sram_cs !== 1'b1 || sram_we !== m0_we || sram_wdata !== m0_wdata || int'(sram_addr) != word_of(m0_addr)) :
                  (sram_cs !== 1'b1 || sram_we !== m1_we || sram_wdata !== m1_wdata || int'(sram_addr) != word_of(m1_addr))) begin
        n_err++;
        $display("FAIL rand_sram[%0d]: got cs=%b we=%h addr=%0d wdata=%h for owner %b",
                 c, sram_cs, sram_we, sram_addr, sram_wdata, eg);
      end
      w0 = exp_rv0 ? exp_rd : '0;
      w1 = exp_rv1 ? exp_rd : '0;
      n_cmp++;
      if ({m1_rvalid, m0_rvalid} !== {exp_rv1, exp_rv0} || m0_rdata !== w0 || m1_rdata !== w1) begin
        n_err++;
        $display("FAIL rand_read[%0d]: got rv=%b m0=%h m1=%h want rv=%b m0=%h m1=%h",
                 c, {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata, {exp_rv1, exp_rv0}, w0, w1);
      end
      prev = eg;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_solo_write_read();
    test_weighting();
    test_addr_wrap();
    test_reset_mid_read();
`ifdef DM_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
